// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Main control FSM for the multi-cycle MIPS-subset CPU. Steps the shared ALU,
// unified memory and register file through FETCH / DECODE / EXECUTE / MEMORY /
// WRITEBACK, waiting in any memory step until mem_ready. Also keeps a count of
// retired instructions and a sticky flag for undecodable opcodes.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-high
//   opcode[5:0]    in   IR[31:26]; only looked at in DECODE and MEM_ADDR
//   mem_ready      in   memory finishes the current read/write this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load if ALU zero
//   iord           out  memory address select: 0 = PC, 1 = ALUOut
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   ir_write       out  IR load
//   mem_to_reg     out  register write data: 1 = MDR, 0 = ALUOut
//   reg_dst        out  destination register: 1 = rd, 0 = rt
//   reg_write      out  register file write enable
//   alu_src_a      out  ALU A: 0 = PC, 1 = A
//   alu_src_b[1:0] out  ALU B: 00 = B, 01 = 4, 10 = simm, 11 = simm << 2
//   aluop[1:0]     out  00 = add, 01 = sub, 10 = funct-decoded
//   pc_source[1:0] out  00 = ALU result, 01 = ALUOut, 10 = jump target
//   state[3:0]     out  current state (debug)
//   instr_count    out  retired-instruction counter, wraps
//   illegal        out  sticky unknown-opcode flag, cleared only by rst
// -----------------------------------------------------------------------------
module multi_cycle_ctrl #(
   parameter logic [5:0]  OP_RTYPE = 6'b000000,
   parameter logic [5:0]  OP_LW    = 6'b100011,
   parameter logic [5:0]  OP_SW    = 6'b101011,
   parameter logic [5:0]  OP_BEQ   = 6'b000100,
   parameter logic [5:0]  OP_J     = 6'b000010,
   parameter logic [5:0]  OP_ADDI  = 6'b001000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       aluop,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count,
   output logic             illegal
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      ALU_WB    = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             ill_q, ill_d;
   logic             retire;

   // ------------------------------------------------------------------------
   // State, counter and sticky flag registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ill_q   <= ill_d;
         if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. retire marks the last cycle of a completed instruction,
   // i.e. the transition back into FETCH that finishes real work.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ill_d   = ill_q;
      retire  = 1'b0;
      case (state_q)
         FETCH: begin
            if (mem_ready) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDI_EXEC;
               default: begin
                  // Unknown opcode: skip the instruction without counting it.
                  ill_d   = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         MEM_ADDR: begin
            state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            if (mem_ready) begin
               state_d = MEM_WB;
            end
         end
         MEM_WB: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         MEM_WRITE: begin
            if (mem_ready) begin
               state_d = FETCH;
               retire  = 1'b1;
            end
         end
         EXECUTE: begin
            state_d = ALU_WB;
         end
         ALU_WB: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         BRANCH: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         JUMP: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         ADDI_EXEC: begin
            state_d = ADDI_WB;
         end
         ADDI_WB: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         default: begin
            // Encodings 12..15 are unreachable; recover quietly.
            state_d = FETCH;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode. Everything is forced low while rst is held so that an
   // aborted instruction cannot leave a partial write behind, even though the
   // state register already reads FETCH.
   // ------------------------------------------------------------------------
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      aluop         = 2'b00;
      pc_source     = 2'b00;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               // IR and PC+4 are captured only on the cycle memory delivers.
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE: begin
               alu_src_b = 2'b11;
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEM_READ: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            EXECUTE: begin
               alu_src_a = 1'b1;
               aluop     = 2'b10;
            end
            ALU_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               aluop         = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            ADDI_WB: begin
               reg_write = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign state       = state_q;
   assign instr_count = cnt_q;
   assign illegal     = ill_q;

endmodule
